// File: rtl/vec_dist_mac_if.sv
// vec_dist_mac_if: handshake and data bundle for vec_dist_mac.
//   master : job requester / beat source / result sink (drives start, mode,
//            len, in_valid, a, b, out_ready)
//   slave  : the vec_dist_mac engine (drives in_ready, out_valid, result,
//            ovf, busy)
interface vec_dist_mac_if #(
  parameter int unsigned DW    = 16,
  parameter int unsigned LANES = 1,
  parameter int unsigned AW    = 36,
  parameter int unsigned LW    = 16
) ();
  logic                  start;
  logic                  mode;
  logic [LW-1:0]         len;
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*DW-1:0]   a;
  logic [LANES*DW-1:0]   b;
  logic                  out_valid;
  logic                  out_ready;
  logic [AW-1:0]         result;
  logic                  ovf;
  logic                  busy;

  modport master (
    output start, mode, len, in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, ovf, busy
  );

  modport slave (
    input  start, mode, len, in_valid, a, b, out_ready,
    output in_ready, out_valid, result, ovf, busy
  );
endinterface

// File: rtl/vec_dist_mac.sv
// vec_dist_mac: streaming multi-lane accumulator computing either a dot
// product (mode 0: sum of a_i*b_i) or an L1 distance (mode 1: sum of |a_i-b_i|)
// over a job of len beats, with a saturating AW-bit accumulator.
// Ports:
//   clk    : sole clock, rising edge
//   reset  : asynchronous, active-low
//   io     : vec_dist_mac_if slave (start/mode/len job request, in_valid/
//            in_ready beat stream a/b, out_valid/out_ready result handshake,
//            result, sticky ovf, busy)
module vec_dist_mac #(
  parameter int unsigned DW    = 16,
  parameter int unsigned LANES = 1,
  parameter int unsigned AW    = 36,
  parameter int unsigned LW    = 16
) (
  input  logic          clk,
  input  logic          reset,
  vec_dist_mac_if.slave io
);
  // Lane-sum width is sized so a full beat can never overflow it.
  localparam int unsigned SW   = 2*DW + $clog2(LANES);
  localparam int unsigned SUMW = ((AW > SW) ? AW : SW) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          r_state;
  state_t          w_next;

  logic            r_mode;
  logic [LW-1:0]   r_len;
  logic [LW-1:0]   r_cnt;
  logic [SW-1:0]   r_s1;
  logic            r_s1_v;
  logic [AW-1:0]   r_acc;
  logic            r_ovf;

  logic [SW-1:0]   w_lane_sum;
  logic [SUMW-1:0] w_sum;
  logic            w_job_start;
  logic            w_accept;
  logic            w_last;

  function automatic logic [DW-1:0] absdiff(input logic [DW-1:0] x,
                                            input logic [DW-1:0] y);
    return (x >= y) ? (x - y) : (y - x);
  endfunction

  always_comb begin
    w_job_start = (r_state == IDLE) && io.start;
    w_accept    = (r_state == RUN) && io.in_valid;
    w_last      = w_accept && (r_cnt == (r_len - LW'(1)));
  end

  // Stage-1 combinational lane reduction
  always_comb begin
    w_lane_sum = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (r_mode)
        w_lane_sum = w_lane_sum + SW'(absdiff(io.a[i*DW +: DW], io.b[i*DW +: DW]));
      else
        w_lane_sum = w_lane_sum + (SW'(io.a[i*DW +: DW]) * SW'(io.b[i*DW +: DW]));
    end
  end

  // One spare bit above the accumulator exposes any carry past 2^AW-1.
  always_comb begin
    w_sum = SUMW'(r_acc) + SUMW'(r_s1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    io.in_ready  = 1'b0;
    io.out_valid = 1'b0;
    io.busy      = 1'b1;
    case (r_state)
      IDLE: begin
        io.busy = 1'b0;
        if (io.start) w_next = (io.len != '0) ? RUN : DONE;
      end
      RUN: begin
        io.in_ready = 1'b1;
        if (w_last) w_next = DRAIN;
      end
      // The final beat sits in stage 1 for one cycle, then stage 2 adds it;
      // leaving once stage 1 is empty places out_valid two edges after
      // the last accept.
      DRAIN: begin
        if (!r_s1_v) w_next = DONE;
      end
      DONE: begin
        io.out_valid = 1'b1;
        if (io.out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mode <= 1'b0;
      r_len  <= '0;
      r_cnt  <= '0;
      r_s1   <= '0;
      r_s1_v <= 1'b0;
      r_acc  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_job_start) begin
        r_mode <= io.mode;
        r_len  <= io.len;
        r_cnt  <= '0;
        r_acc  <= '0;
        r_ovf  <= 1'b0;
      end
      if (w_accept) begin
        r_cnt <= r_cnt + LW'(1);
        r_s1  <= w_lane_sum;
      end
      r_s1_v <= w_accept;
      // r_s1_v is never set in IDLE, so this cannot collide with the clear.
      if (r_s1_v) begin
        if (w_sum[SUMW-1:AW] != '0) begin
          r_acc <= '1;
          r_ovf <= 1'b1;
        end else begin
          r_acc <= w_sum[AW-1:0];
        end
      end
    end
  end

  assign io.result = r_acc;
  assign io.ovf    = r_ovf;
endmodule

// File: tb/tb_vec_dist_mac.sv
// tb_vec_dist_mac: self-checking bench for vec_dist_mac. The DUT is built with
// LANES=2, AW=33 so the saturation and multi-lane scenarios share one
// instance; single-lane vectors keep lane 1 at zero.
module tb_vec_dist_mac;
  localparam int unsigned DW    = 16;
  localparam int unsigned LANES = 2;
  localparam int unsigned AW    = 33;
  localparam int unsigned LW    = 16;
  localparam longint unsigned MAXV = (64'd1 << AW) - 64'd1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vec_dist_mac_if #(.DW(DW), .LANES(LANES), .AW(AW), .LW(LW)) io ();

  vec_dist_mac #(.DW(DW), .LANES(LANES), .AW(AW), .LW(LW)) u_dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [LANES*DW-1:0] q_a[$];
  logic [LANES*DW-1:0] q_b[$];
  int                  q_gap[$];
  int                  lat;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LANES*DW-1:0] pk(input int unsigned l0, input int unsigned l1);
    logic [LANES*DW-1:0] v;
    v = '0;
    v[0 +: DW]  = DW'(l0);
    v[DW +: DW] = DW'(l1);
    return v;
  endfunction

  task automatic clear_beats();
    q_a.delete();
    q_b.delete();
    q_gap.delete();
  endtask

  task automatic add_beat(input int unsigned a0, input int unsigned a1,
                          input int unsigned b0, input int unsigned b1, input int gap);
    q_a.push_back(pk(a0, a1));
    q_b.push_back(pk(b0, b1));
    q_gap.push_back(gap);
  endtask

  // Exact mathematical total of the queued job, unbounded by AW.
  function automatic longint unsigned model_total(input bit m);
    longint unsigned tot = 0;
    longint unsigned mask = (64'd1 << DW) - 64'd1;
    for (int k = 0; k < q_a.size(); k++) begin
      for (int l = 0; l < LANES; l++) begin
        longint unsigned x = (longint'(q_a[k]) >> (l*DW)) & mask;
        longint unsigned y = (longint'(q_b[k]) >> (l*DW)) & mask;
        if (m) tot += (x > y) ? (x - y) : (y - x);
        else   tot += x * y;
      end
    end
    return tot;
  endfunction

  function automatic longint unsigned model_result(input bit m);
    longint unsigned t = model_total(m);
    return (t > MAXV) ? MAXV : t;
  endfunction

  // Drives one job from IDLE through to out_valid; lat = edges from the
  // accepting edge of the last beat to out_valid (20 = never seen).
  task automatic do_job(input bit m, input int n);
    int idx = 0;
    int gapc = 0;
    int budget = 0;
    lat = 0;
    io.start = 1'b1;
    io.mode  = m;
    io.len   = LW'(n);
    tick();
    io.start = 1'b0;
    io.mode  = 1'($urandom);
    io.len   = LW'($urandom);
    while (idx < n && budget < 500) begin
      if (gapc < q_gap[idx]) begin
        io.in_valid = 1'b0;
        io.a = LANES*DW'($urandom);
        io.b = LANES*DW'($urandom);
        gapc++;
      end else begin
        io.in_valid = 1'b1;
        io.a = q_a[idx];
        io.b = q_b[idx];
        if (io.in_ready) begin
          idx++;
          gapc = 0;
        end
      end
      tick();
      budget++;
    end
    io.in_valid = 1'b0;
    while (!io.out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic release_result();
    io.out_ready = 1'b1;
    tick();
    io.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    io.start = 1'b0; io.mode = 1'b0; io.len = '0; io.in_valid = 1'b0;
    io.a = '0; io.b = '0; io.out_ready = 1'b0;
    #1;
    n_checks++; if (io.in_ready !== 1'b0) begin n_errors++; $display("FAIL reset_in_ready: got %b expected 0", io.in_ready); end
    n_checks++; if (io.out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b expected 0", io.out_valid); end
    n_checks++; if (io.busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", io.busy); end
    n_checks++; if (io.result !== '0) begin n_errors++; $display("FAIL reset_result: got %0d expected 0", io.result); end
    n_checks++; if (io.ovf !== 1'b0) begin n_errors++; $display("FAIL reset_ovf: got %b expected 0", io.ovf); end
    tick(); tick();
    reset = 1'b1;
    tick();
    n_checks++; if (io.busy !== 1'b0) begin n_errors++; $display("FAIL reset_idle_busy: got %b expected 0", io.busy); end
  endtask

  task automatic load_basic();
    clear_beats();
    add_beat(5, 0, 10, 0, 0);
    add_beat(3, 0, 4, 0, 0);
    add_beat(1, 0, 6, 0, 0);
    add_beat(2, 0, 3, 0, 0);
  endtask

  task automatic test_mac();
    load_basic();
    do_job(1'b0, 4);
    n_checks++; if (lat !== 2) begin n_errors++; $display("FAIL mac_latency: got %0d expected 2", lat); end
    n_checks++; if (io.result !== AW'(74)) begin n_errors++; $display("FAIL mac_result: got %0d expected 74", io.result); end
    n_checks++; if (io.ovf !== 1'b0) begin n_errors++; $display("FAIL mac_ovf: got %b expected 0", io.ovf); end
    n_checks++; if (io.busy !== 1'b1) begin n_errors++; $display("FAIL mac_busy_done: got %b expected 1", io.busy); end
    release_result();
    n_checks++; if (io.out_valid !== 1'b0) begin n_errors++; $display("FAIL mac_out_valid_drop: got %b expected 0", io.out_valid); end
    n_checks++; if (io.result !== AW'(74)) begin n_errors++; $display("FAIL mac_result_hold_idle: got %0d expected 74", io.result); end
  endtask

  task automatic test_l1();
    load_basic();
    do_job(1'b1, 4);
    n_checks++; if (lat !== 2) begin n_errors++; $display("FAIL l1_latency: got %0d expected 2", lat); end
    n_checks++; if (io.result !== AW'(12)) begin n_errors++; $display("FAIL l1_result: got %0d expected 12", io.result); end
    release_result();
  endtask

  task automatic test_saturate();
    clear_beats();
    for (int k = 0; k < 3; k++) add_beat(65535, 0, 65535, 0, 0);
    do_job(1'b0, 3);
    n_checks++; if (io.result !== AW'(MAXV)) begin n_errors++; $display("FAIL sat_result: got %0d expected %0d", io.result, MAXV); end
    n_checks++; if (io.ovf !== 1'b1) begin n_errors++; $display("FAIL sat_ovf: got %b expected 1", io.ovf); end
    release_result();
    n_checks++; if (io.ovf !== 1'b1) begin n_errors++; $display("FAIL sat_ovf_hold_idle: got %b expected 1", io.ovf); end
  endtask

  task automatic test_len_zero();
    io.start = 1'b1;
    io.len = '0;
    io.in_valid = 1'b1;
    io.a = pk(7, 7);
    io.b = pk(9, 9);
    n_checks++; if (io.in_ready !== 1'b0) begin n_errors++; $display("FAIL len0_in_ready_idle: got %b expected 0", io.in_ready); end
    tick();
    io.start = 1'b0;
    n_checks++; if (io.out_valid !== 1'b1) begin n_errors++; $display("FAIL len0_out_valid: got %b expected 1", io.out_valid); end
    n_checks++; if (io.in_ready !== 1'b0) begin n_errors++; $display("FAIL len0_in_ready_done: got %b expected 0", io.in_ready); end
    n_checks++; if (io.result !== '0) begin n_errors++; $display("FAIL len0_result: got %0d expected 0", io.result); end
    n_checks++; if (io.ovf !== 1'b0) begin n_errors++; $display("FAIL len0_ovf_cleared: got %b expected 0", io.ovf); end
    io.in_valid = 1'b0;
    release_result();
  endtask

  task automatic test_lanes_gap();
    clear_beats();
    add_beat(2, 3, 4, 5, 0);
    add_beat(2, 3, 4, 5, 3);
    do_job(1'b0, 2);
    n_checks++; if (io.result !== AW'(46)) begin n_errors++; $display("FAIL lanes_result: got %0d expected 46", io.result); end
    io.out_ready = 1'b0;
    io.start = 1'b1;
    io.len = LW'(5);
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++; if (io.result !== AW'(46)) begin n_errors++; $display("FAIL lanes_hold_result: got %0d expected 46", io.result); end
      n_checks++; if (io.out_valid !== 1'b1) begin n_errors++; $display("FAIL lanes_hold_valid: got %b expected 1", io.out_valid); end
    end
    io.out_ready = 1'b1;
    tick();
    io.out_ready = 1'b0;
    io.start = 1'b0;
    n_checks++; if (io.busy !== 1'b0) begin n_errors++; $display("FAIL start_ignored_on_exit: got busy %b expected 0", io.busy); end
  endtask

  task automatic test_reset_midjob();
    io.start = 1'b1;
    io.mode = 1'b0;
    io.len = LW'(4);
    tick();
    io.start = 1'b0;
    io.in_valid = 1'b1;
    io.a = pk(100, 50);
    io.b = pk(200, 60);
    tick();
    tick();
    io.in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    n_checks++; if (io.busy !== 1'b0) begin n_errors++; $display("FAIL midreset_busy: got %b expected 0", io.busy); end
    n_checks++; if (io.result !== '0) begin n_errors++; $display("FAIL midreset_result: got %0d expected 0", io.result); end
    tick();
    reset = 1'b1;
    tick();
    load_basic();
    do_job(1'b0, 4);
    n_checks++; if (io.result !== AW'(74)) begin n_errors++; $display("FAIL midreset_rerun: got %0d expected 74", io.result); end
    release_result();
  endtask

  task automatic test_random();
    for (int j = 0; j < 25; j++) begin
      bit m;
      int n;
      bit big;
      longint unsigned exp_r;
      bit exp_o;
      clear_beats();
      m = 1'($urandom);
      n = $urandom_range(1, 6);
      big = 1'($urandom);
      for (int k = 0; k < n; k++) begin
        if (big) add_beat($urandom_range(0, 65535), $urandom_range(0, 65535),
                          $urandom_range(0, 65535), $urandom_range(0, 65535), $urandom_range(0, 2));
        else     add_beat($urandom_range(0, 255), $urandom_range(0, 255),
                          $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 2));
      end
      exp_r = model_result(m);
      exp_o = (model_total(m) > MAXV);
      do_job(m, n);
      n_checks++; if (lat !== 2) begin n_errors++; $display("FAIL rand_latency job %0d: got %0d expected 2", j, lat); end
      n_checks++; if (io.result !== AW'(exp_r)) begin n_errors++; $display("FAIL rand_result job %0d: got %0d expected %0d", j, io.result, exp_r); end
      n_checks++; if (io.ovf !== exp_o) begin n_errors++; $display("FAIL rand_ovf job %0d: got %b expected %b", j, io.ovf, exp_o); end
      repeat ($urandom_range(0, 2)) tick();
      release_result();
      n_checks++; if (io.out_valid !== 1'b0) begin n_errors++; $display("FAIL rand_exit job %0d: got %b expected 0", j, io.out_valid); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mac();
    test_l1();
    test_saturate();
    test_len_zero();
    test_lanes_gap();
    test_reset_midjob();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/vec_dist_mac.md
VEC_DIST_MAC -- requirements
Module: vec_dist_mac

Interface
REQ-001 The block SHALL have parameter DW, default 16, giving the per-element operand width (unsigned).
REQ-002 The block SHALL have parameter LANES, default 1, giving the number of element pairs consumed per beat (1..8).
REQ-003 The block SHALL have parameter AW, default 36, giving the accumulator and result width, with AW >= 2*DW.
REQ-004 The block SHALL have parameter LW, default 16, giving the width of the beat-count input.
REQ-005 clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset; it SHALL be asserted at 0.
REQ-007 start  input  1  job request, sampled only in IDLE.
REQ-008 mode  input  1  0 = MAC (sum of a*b), 1 = L1 distance (sum of |a-b|); captured at job start.
REQ-009 len  input  LW  number of beats in the job; captured at job start.
REQ-010 in_valid  input  1  a/b beat valid.
REQ-011 in_ready  output  1  beat accepted when in_valid & in_ready.
REQ-012 a, b  input  LANES*DW each  lane i occupies bits [i*DW +: DW].
REQ-013 out_valid  output  1  result valid.
REQ-014 out_ready  input  1  result accepted when out_valid & out_ready.
REQ-015 result  output  AW  accumulated value.
REQ-016 ovf  output  1  sticky saturation flag for the current job.
REQ-017 busy  output  1  high in any state other than IDLE.

Function
REQ-018 FSM states SHALL be IDLE, RUN, DRAIN and DONE.
REQ-019 In IDLE, start with len != 0 SHALL capture mode and len, clear the accumulator and ovf, and go to RUN.
REQ-020 In IDLE, start with len == 0 SHALL clear the accumulator and ovf and go directly to DONE, giving result = 0.
REQ-021 in_ready SHALL be 1 only in RUN; in_valid outside RUN SHALL be ignored with no state change.
REQ-022 Stage 1 SHALL register the per-accepted-beat lane sum: sum over i of a_i*b_i (MAC) or |a_i-b_i| (L1). The lane sum width SHALL be 2*DW+clog2(LANES) and SHALL not overflow.
REQ-023 Stage 2 SHALL add the stage-1 value into the AW-bit accumulator one cycle after stage 1.
REQ-024 RUN SHALL count accepted beats and go to DRAIN on the edge that accepts beat number len.
REQ-025 DRAIN SHALL go to DONE once the final beat's stage-2 add is complete.
REQ-026 out_valid SHALL assert on the 2nd rising edge after the edge that accepted the last beat.
REQ-027 Gaps in in_valid SHALL stall the job without corrupting the accumulator.
REQ-028 If an add would exceed 2^AW-1, the accumulator SHALL saturate to 2^AW-1 and ovf SHALL set; ovf SHALL hold until the next job start.
REQ-029 In DONE, result and ovf SHALL stay stable while out_ready = 0.
REQ-030 In DONE, out_ready = 1 SHALL return the FSM to IDLE; out_valid SHALL drop on the same edge.
REQ-031 start SHALL be ignored in RUN, DRAIN and DONE, including the DONE-exit cycle; a new job SHALL require start in IDLE.
REQ-032 result SHALL be driven from the accumulator register and SHALL be 0 in IDLE until the first job completes. After a job completes it SHALL hold the last value until the next start.

Reset
REQ-033 reset = 0 SHALL immediately force IDLE and clear the beat count, pipeline valid bits, accumulator and ovf. Outputs SHALL be in_ready = 0, out_valid = 0, busy = 0, result = 0 and ovf = 0, regardless of the clock.
REQ-034 A reset asserted mid-job SHALL abort the job; after release the block SHALL accept a fresh start with no residual accumulation.

Verification
REQ-035 MAC with defaults: start, mode = 0, len = 4, then beats (5,10), (3,4), (1,6), (2,3) back-to-back -> result = 74, ovf = 0, out_valid 2 edges after the 4th beat.
REQ-036 Same beats with mode = 1 -> result = 12.
REQ-037 len = 0 -> DONE reached with no beats, result = 0; beats offered meanwhile see in_ready = 0.
REQ-038 AW = 33, DW = 16: three beats of (65535,65535) -> result = 8589934591, ovf = 1.
REQ-039 LANES = 2, MAC, len = 2, beats a = {2,3}, b = {4,5} twice with a 3-cycle in_valid gap between them -> result = 46. Then hold out_ready = 0 for 3 cycles -> result stays 46 and out_valid stays 1.
REQ-040 Drive reset = 0 after 2 of 4 beats, release it, then run the REQ-035 job -> result = 74.
